serial_tx_sched: RTL

// - Round-robin scheduler and serializer that shares one serial line among NUM_REQ byte producers.
// - Each accepted byte goes out as one frame: start bit 0, 8 data bits LSB first, optional parity bit, stop bit 1.
// - Drives the serial receiver FSM's din input; line idles at 1.

---
 rtl/serial_pkg.sv | 31 +++
 rtl/rr_arbiter.sv | 31 +++
 rtl/serial_tx_sched.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/serial_pkg.sv
// Shared types and constants for the serial transmit scheduler.
// Frame length and the parity state depend on SERIAL_TX_PARITY_EN.
package serial_pkg;

  localparam int unsigned BYTE_W    = 8;
  localparam logic        START_BIT = 1'b0;
  localparam logic        STOP_BIT  = 1'b1;

`ifdef SERIAL_TX_PARITY_EN
  localparam int unsigned FRAME_LEN = 11;
`else
  localparam int unsigned FRAME_LEN = 10;
`endif

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
`ifdef SERIAL_TX_PARITY_EN
    ST_PARITY,
`endif
    ST_STOP,
    ST_GAP
  } tx_state_e;

  // Odd parity: data plus parity bit carries an odd number of ones.
  function automatic logic odd_parity(input logic [BYTE_W-1:0] d);
    return ~(^d);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: first requester at or after ptr wins.
// Pure combinational; one-hot grant plus encoded index.
module rr_arbiter #(
  parameter int unsigned N = 2,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt_c,
  output logic [IW-1:0] idx_c,
  output logic          any_c
);

  always_comb begin
    int unsigned j;
    gnt_c = '0;
    idx_c = '0;
    any_c = 1'b0;
    j     = 0;
    for (int unsigned i = 0; i < N; i++) begin
      j = 32'(ptr) + i;
      if (j >= N) j = j - N;
      if (!any_c && req[IW'(j)]) begin
        any_c           = 1'b1;
        gnt_c[IW'(j)]   = 1'b1;
        idx_c           = IW'(j);
      end
    end
  end

endmodule

// File: rtl/serial_tx_sched.sv
// Round-robin scheduler + serializer sharing one serial line among NUM_REQ byte producers.
// Optional odd-parity bit enabled by defining SERIAL_TX_PARITY_EN.
module serial_tx_sched
  import serial_pkg::*;
#(
  parameter int unsigned NUM_REQ  = 2,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned IDLE_GAP = 0,
  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      dout,
  output logic                      busy,
  output logic [IDX_W-1:0]          grant_id,
  output logic                      frame_done
);

  localparam int unsigned GAP_W = 4;

`ifdef SERIAL_TX_PARITY_EN
  localparam int unsigned PAR_LEN = 1;
`else
  localparam int unsigned PAR_LEN = 0;
`endif

  if (DATA_W != BYTE_W) begin : g_bad_data_w
    $error("DATA_W must equal BYTE_W");
  end
  if (FRAME_LEN != BYTE_W + 2 + PAR_LEN) begin : g_bad_frame_len
    $error("FRAME_LEN inconsistent with parity configuration");
  end
  if (IDLE_GAP > 15) begin : g_bad_gap
    $error("IDLE_GAP must be 0..15");
  end

  tx_state_e          state_q, state_d;
  logic [2:0]         bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0]  shift_q, shift_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [IDX_W-1:0]   grant_id_d;
  logic               dout_d, busy_d, frame_done_d;
  logic [NUM_REQ-1:0] arb_gnt;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;
  logic [BYTE_W-1:0]  sel_byte;
`ifdef SERIAL_TX_PARITY_EN
  logic               parity_q, parity_d;
`endif

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req   (req_valid),
    .ptr   (ptr_q),
    .gnt_c (arb_gnt),
    .idx_c (arb_idx),
    .any_c (arb_any)
  );

  assign req_ready = (state_q == ST_IDLE) ? arb_gnt : '0;

  // One-hot byte mux for the granted requester
  always_comb begin
    sel_byte = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (arb_gnt[i]) sel_byte = req_data[i*DATA_W +: BYTE_W];
    end
  end

  // Next state and next registered outputs; dout_d is the line value for the next cycle
  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    gap_cnt_d    = gap_cnt_q;
    ptr_d        = ptr_q;
    grant_id_d   = grant_id;
    dout_d       = STOP_BIT;
    busy_d       = 1'b1;
    frame_done_d = 1'b0;
`ifdef SERIAL_TX_PARITY_EN
    parity_d     = parity_q;
`endif
    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (arb_any) begin
          state_d    = ST_START;
          shift_d    = sel_byte;
          grant_id_d = arb_idx;
          ptr_d      = (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + IDX_W'(1);
          dout_d     = START_BIT;
          busy_d     = 1'b1;
`ifdef SERIAL_TX_PARITY_EN
          parity_d   = odd_parity(sel_byte);
`endif
        end
      end
      ST_START: begin
        state_d   = ST_DATA;
        bit_cnt_d = 3'd0;
        dout_d    = shift_q[0];
        shift_d   = shift_q >> 1;
      end
      ST_DATA: begin
        if (bit_cnt_q == 3'd7) begin
`ifdef SERIAL_TX_PARITY_EN
          state_d      = ST_PARITY;
          dout_d       = parity_q;
`else
          state_d      = ST_STOP;
          dout_d       = STOP_BIT;
          frame_done_d = 1'b1;
`endif
        end else begin
          bit_cnt_d = bit_cnt_q + 3'd1;
          dout_d    = shift_q[0];
          shift_d   = shift_q >> 1;
        end
      end
`ifdef SERIAL_TX_PARITY_EN
      ST_PARITY: begin
        state_d      = ST_STOP;
        dout_d       = STOP_BIT;
        frame_done_d = 1'b1;
      end
`endif
      ST_STOP: begin
        if (IDLE_GAP == 0) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          state_d   = ST_GAP;
          gap_cnt_d = '0;
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_W'(IDLE_GAP - 1)) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      gap_cnt_q  <= '0;
      ptr_q      <= '0;
      grant_id   <= '0;
      dout       <= STOP_BIT;
      busy       <= 1'b0;
      frame_done <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
      parity_q   <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      gap_cnt_q  <= gap_cnt_d;
      ptr_q      <= ptr_d;
      grant_id   <= grant_id_d;
      dout       <= dout_d;
      busy       <= busy_d;
      frame_done <= frame_done_d;
`ifdef SERIAL_TX_PARITY_EN
      parity_q   <= parity_d;
`endif
    end
  end

endmodule
